// File: rtl/e203_irq_sync_unit.sv
// Interrupt-request synchronizer: four independent asynchronous-clear flop chains
// bring the external, software, timer and debug request levels into the clk domain.

module e203_irq_sync_cell #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    localparam int unsigned DEPTH = SYNC_STAGES;

    logic [DEPTH-1:0] stage;

    // Shift chain: stage[0] samples the async level, the last stage drives q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= '0;
        end else begin
            stage <= {stage[DEPTH-2:0], d};
        end
    end

    assign q = stage[DEPTH-1];

endmodule

module e203_irq_sync_unit #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ext_irq_a,
    input  logic sft_irq_a,
    input  logic tmr_irq_a,
    input  logic dbg_irq_a,
    output logic ext_irq_r,
    output logic sft_irq_r,
    output logic tmr_irq_r,
    output logic dbg_irq_r
);

    e203_irq_sync_cell #(.SYNC_STAGES(SYNC_STAGES)) u_ext_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ext_irq_a),
        .q     (ext_irq_r)
    );

    e203_irq_sync_cell #(.SYNC_STAGES(SYNC_STAGES)) u_sft_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sft_irq_a),
        .q     (sft_irq_r)
    );

    e203_irq_sync_cell #(.SYNC_STAGES(SYNC_STAGES)) u_tmr_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (tmr_irq_a),
        .q     (tmr_irq_r)
    );

    e203_irq_sync_cell #(.SYNC_STAGES(SYNC_STAGES)) u_dbg_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (dbg_irq_a),
        .q     (dbg_irq_r)
    );

endmodule

// File: tb/tb_e203_irq_sync_unit.sv
// Bench for e203_irq_sync_unit: a history-based model predicts every output at each
// rising edge into a scoreboard queue; an independent monitor pops and compares.

module tb_e203_irq_sync_unit;

    localparam int unsigned SYNC_STAGES = 2;

    logic       clk;
    logic       rst_n;
    logic [3:0] irq_a;   // {ext, sft, tmr, dbg}
    logic       ext_irq_r, sft_irq_r, tmr_irq_r, dbg_irq_r;
    logic [3:0] irq_r;

    int checks;
    int errors;

    logic [3:0] hist[$];  // input levels sampled since the last reset
    logic [3:0] sb[$];    // expected outputs, one per rising edge

    assign irq_r = {ext_irq_r, sft_irq_r, tmr_irq_r, dbg_irq_r};

    e203_irq_sync_unit #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ext_irq_a (irq_a[3]),
        .sft_irq_a (irq_a[2]),
        .tmr_irq_a (irq_a[1]),
        .dbg_irq_a (irq_a[0]),
        .ext_irq_r (ext_irq_r),
        .sft_irq_r (sft_irq_r),
        .tmr_irq_r (tmr_irq_r),
        .dbg_irq_r (dbg_irq_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Reference model: an output is the level sampled SYNC_STAGES-1 edges earlier, or 0
    // if fewer than SYNC_STAGES edges have elapsed since reset was released.
    always @(negedge rst_n) hist.delete();

    always @(posedge clk) begin
        logic [3:0] exp;
        if (!rst_n) begin
            hist.delete();
        end else begin
            hist.push_back(irq_a);
            if (hist.size() > SYNC_STAGES) void'(hist.pop_front());
        end
        if (hist.size() >= SYNC_STAGES) exp = hist[hist.size() - SYNC_STAGES];
        else                            exp = 4'b0000;
        sb.push_back(exp);
    end

    // Monitor: compare just after each rising edge against the scoreboard.
    always @(posedge clk) begin
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty at %0t: got no entry expected one", $time);
        end else begin
            check("edge_outputs", irq_r, sb.pop_front());
        end
    end

    task automatic hold(input logic [3:0] v, input int cycles);
        irq_a = v;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        irq_a  = 4'b1111;
        #1;
        check("reset_no_clock", irq_r, 4'b0000);

        // Reset held with all inputs high; release and let the level propagate.
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        hold(4'b1111, 3);
        hold(4'b0000, 3);

        // Latency on ext only, rising then falling.
        hold(4'b1000, 4);
        hold(4'b0000, 4);

        // Single-edge pulse on tmr.
        hold(4'b0010, 1);
        hold(4'b0000, 4);

        // sft high, async reset before it reaches the output.
        irq_a = 4'b0100;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_rst_sft_early", irq_r, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        hold(4'b0100, 4);

        // Async reset with all outputs high: must clear with no clock edge.
        hold(4'b1111, 4);
        @(posedge clk);
        #2 check("pre_reset_all_high", irq_r, 4'b1111);
        rst_n = 1'b0;
        #1 check("async_rst_all_high", irq_r, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        hold(4'b1111, 4);

        // Simultaneous toggle of all four inputs.
        hold(4'b0000, 3);
        hold(4'b1111, 3);
        hold(4'b0000, 3);

        // Random independence traffic.
        for (int i = 0; i < 1000; i++) begin
            irq_a = 4'($urandom_range(0, 15));
            @(negedge clk);
        end

        hold(4'b0000, 4);
        @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
